// File: rtl/encoder_pulse_cond.sv
// encoder_pulse_cond
//
// Turns the raw, bouncing wheel-encoder signal into one clean single-cycle
// stim pulse per accepted rising edge for the rotation-time counter. It also
// measures the spacing between pulses and flags a wheel that has stopped.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous, active-high reset
//   enc_in        raw encoder input, asynchronous to clk, may bounce
//   en            conditioning enable; low holds the block idle
//   stim          one-cycle pulse per accepted rising edge
//   level         debounced encoder level
//   pulse_period  cycles between the last two stim pulses (saturates at STALL_CYCLES)
//   period_valid  one-cycle pulse with stim whenever pulse_period updates
//   stall         high while no stim has been seen for STALL_CYCLES cycles
//
// Debounce FSM
//   state     | meaning
//   ----------+-------------------------------------------------------
//   LOW       | debounced level 0, waiting for the synced input to rise
//   RISE_CHK  | input high, counting stable samples before accepting
//   HIGH      | debounced level 1, waiting for the synced input to fall
//   FALL_CHK  | input low, counting stable samples before accepting

module encoder_pulse_cond #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int STALL_CYCLES    = 50000,
   parameter int PER_W           = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enc_in,
   input  logic             en,
   output logic             stim,
   output logic             level,
   output logic [PER_W-1:0] pulse_period,
   output logic             period_valid,
   output logic             stall
);

   // The count value at which the next matching sample completes the
   // debounce window (DEBOUNCE_CYCLES samples including the entry sample).
   localparam logic [7:0]       DB_LAST  = 8'(DEBOUNCE_CYCLES - 2);
   localparam logic [PER_W-1:0] STALL_TC = PER_W'(STALL_CYCLES);

   typedef enum logic [1:0] {
      ST_LOW      = 2'd0,
      ST_RISE_CHK = 2'd1,
      ST_HIGH     = 2'd2,
      ST_FALL_CHK = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;

   state_t                 state_q;
   state_t                 state_d;
   logic [7:0]             cnt_q;
   logic [7:0]             cnt_d;
   logic                   rise_acc;
   logic                   stim_q;

   logic [PER_W-1:0]       timer_q;
   logic                   first_q;
   logic [PER_W-1:0]       pulse_period_q;
   logic                   pv_q;

   // ------------------------------------------------------------------
   // Synchroniser: runs regardless of en so a level present when en
   // returns has already been brought into the clock domain.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], enc_in};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Debounce FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_LOW;
         cnt_q   <= 8'd0;
         stim_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stim_q  <= rise_acc;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rise_acc = 1'b0;

      unique case (state_q)
         ST_LOW: begin
            if (s) begin
               state_d = ST_RISE_CHK;
               cnt_d   = 8'd0;
            end
         end

         ST_RISE_CHK: begin
            if (!s) begin
               state_d = ST_LOW;
            end else if (cnt_q == DB_LAST) begin
               state_d  = ST_HIGH;
               rise_acc = 1'b1;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         ST_HIGH: begin
            if (!s) begin
               state_d = ST_FALL_CHK;
               cnt_d   = 8'd0;
            end
         end

         ST_FALL_CHK: begin
            if (s) begin
               state_d = ST_HIGH;
            end else if (cnt_q == DB_LAST) begin
               state_d = ST_LOW;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         default: begin
            state_d = ST_LOW;
            cnt_d   = 8'd0;
         end
      endcase

      // Disabled: park in LOW with a clean count, never accept an edge.
      if (!en) begin
         state_d  = ST_LOW;
         cnt_d    = 8'd0;
         rise_acc = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Period timer. The accepted-edge event (rise_acc) is acted on at the
   // same edge that raises stim, so pulse_period and period_valid change
   // in the stim cycle. The timer restarts at 1 so that the value read at
   // the next stim equals the stim-to-stim spacing.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q        <= '0;
         first_q        <= 1'b1;
         pulse_period_q <= '0;
         pv_q           <= 1'b0;
      end else if (!en) begin
         timer_q <= '0;
         first_q <= 1'b1;
         pv_q    <= 1'b0;
      end else if (rise_acc) begin
         timer_q <= PER_W'(1);
         first_q <= 1'b0;
         pv_q    <= !first_q;
         if (!first_q) begin
            pulse_period_q <= timer_q;
         end
      end else begin
         pv_q <= 1'b0;
         if (timer_q != STALL_TC) begin
            timer_q <= timer_q + PER_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs. A stim reloads the timer to 1, so stall is already low in
   // the stim cycle even if saturation would have coincided with it.
   // ------------------------------------------------------------------
   assign stim         = stim_q & en;
   assign period_valid = pv_q & en;
   assign stall        = en & (timer_q == STALL_TC);
   assign level        = (state_q == ST_HIGH) || (state_q == ST_FALL_CHK);
   assign pulse_period = pulse_period_q;

endmodule

// File: tb/tb_encoder_pulse_cond.sv
// Bench for encoder_pulse_cond: one default-parameter instance (a) and one
// short-window instance (b: DEBOUNCE_CYCLES=4, STALL_CYCLES=200).
module tb_encoder_pulse_cond;

   localparam int PER_W = 20;

   logic             clk = 1'b0;
   logic             rst;
   logic             enc_a, en_a, stim_a, level_a, pv_a, stall_a;
   logic [PER_W-1:0] pp_a;
   logic             enc_b, en_b, stim_b, level_b, pv_b, stall_b;
   logic [PER_W-1:0] pp_b;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   encoder_pulse_cond #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .STALL_CYCLES(50000), .PER_W(PER_W)
   ) u_a (
      .clk(clk), .rst(rst), .enc_in(enc_a), .en(en_a),
      .stim(stim_a), .level(level_a), .pulse_period(pp_a),
      .period_valid(pv_a), .stall(stall_a)
   );

   encoder_pulse_cond #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .STALL_CYCLES(200), .PER_W(PER_W)
   ) u_b (
      .clk(clk), .rst(rst), .enc_in(enc_b), .en(en_b),
      .stim(stim_b), .level(level_b), .pulse_period(pp_b),
      .period_valid(pv_b), .stall(stall_b)
   );

   typedef struct {
      logic enc;
      logic stim;
      logic level;
      logic pv;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic enc, input logic st, input logic lv, input logic pv);
      vec_t v;
      v.enc = enc; v.stim = st; v.level = lv; v.pv = pv;
      tbl.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int last_stim_cyc;
      int extra;
      logic any_stall;
      logic found;

      // DUT b vectors, hand-derived: the FSM sees enc two edges late, the
      // window accepts on the 4th consecutive sample, stim on edge 2+4-1.
      // seg 1 (rows 0-9): 3 high samples then low -> rejected
      for (int j = 0; j < 10; j++) add(j < 3, 1'b0, 1'b0, 1'b0);
      // seg 2 (rows 10-25): 6 high samples -> stim at j=5, level j=5..10
      for (int j = 0; j < 16; j++) add(j < 6, j == 5, (j >= 5) && (j <= 10), 1'b0);
      // seg 3 (rows 26-55): bounce 1,1,0,0 for 10 samples, stable high
      // from j=8 to 19, then low; stim 5 edges after j=8 (j=13)
      for (int j = 0; j < 30; j++)
         add((j < 10) ? ((j % 4) < 2) : (j < 20), j == 13, (j >= 13) && (j <= 24), j == 13);

      rst = 1'b1; en_a = 1'b1; en_b = 1'b1; enc_a = 1'b0; enc_b = 1'b0;
      repeat (3) tick();
      chk("rst_a_stim", stim_a, 0);
      chk("rst_a_level", level_a, 0);
      chk("rst_a_pp", pp_a, 0);
      chk("rst_a_pv", pv_a, 0);
      chk("rst_a_stall", stall_a, 0);
      chk("rst_b_stim", stim_b, 0);
      chk("rst_b_level", level_b, 0);
      chk("rst_b_pp", pp_b, 0);
      chk("rst_b_stall", stall_b, 0);
      rst = 1'b0;

      // ---- table-driven debounce vectors on b ----
      last_stim_cyc = 0;
      foreach (tbl[i]) begin
         enc_b = tbl[i].enc;
         tick();
         chk($sformatf("tbl%0d_stim", i), stim_b, tbl[i].stim);
         chk($sformatf("tbl%0d_level", i), level_b, tbl[i].level);
         chk($sformatf("tbl%0d_pv", i), pv_b, tbl[i].pv);
         if (tbl[i].stim) last_stim_cyc = cyc;
      end
      // stims at rows 15 and 39 -> 24 cycles apart
      chk("tbl_pp", pp_b, 24);

      // ---- stall: timer is 1 in the stim cycle, reaches 200 199 cycles later ----
      found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
         tick();
         if (stall_b) found = 1'b1;
      end
      chk("stall1_seen", found, 1);
      chk("stall1_delay", cyc - last_stim_cyc, 199);

      // pulse while stalled: clears stall, period saturated at 200
      enc_b = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i < 5) begin
            chk("stall_hold", stall_b, 1);
            chk("stall_nostim", stim_b, 0);
         end else begin
            chk("stall_clr_stim", stim_b, 1);
            chk("stall_clr_stall", stall_b, 0);
            chk("stall_clr_pv", pv_b, 1);
            chk("stall_clr_pp", pp_b, 200);
            last_stim_cyc = cyc;
         end
      end
      enc_b = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
         tick();
         if (stall_b) found = 1'b1;
      end
      chk("stall2_delay", cyc - last_stim_cyc, 199);

      // ---- en low for 5 cycles while stalled ----
      en_b = 1'b0;
      #1;
      chk("en0_stall_comb", stall_b, 0);
      for (int i = 0; i < 5; i++) begin
         enc_b = (i < 2);
         tick();
         chk("en0_stim", stim_b, 0);
         chk("en0_stall", stall_b, 0);
         chk("en0_pv", pv_b, 0);
         chk("en0_pp", pp_b, 200);
      end
      en_b = 1'b1;
      enc_b = 1'b0;

      // ---- pulse train, 150 cycles apart, restarted as after reset ----
      extra = 0;
      any_stall = 1'b0;
      for (int p = 0; p < 4; p++) begin
         for (int j = 0; j < 150; j++) begin
            enc_b = (j < 6);
            tick();
            if (stall_b) any_stall = 1'b1;
            if (j == 5) begin
               chk($sformatf("train%0d_stim", p), stim_b, 1);
               chk($sformatf("train%0d_pv", p), pv_b, p > 0);
               if (p > 0) chk($sformatf("train%0d_pp", p), pp_b, 150);
            end else if (stim_b) begin
               extra++;
            end
         end
      end
      chk("train_extra_stim", extra, 0);
      chk("train_stall", any_stall, 0);

      // ---- default instance: clean edge, latency 17 ----
      for (int i = 0; i < 100; i++) begin
         enc_a = 1'b1;
         tick();
         chk($sformatf("a_rise%0d_stim", i), stim_a, i == 17);
         chk($sformatf("a_rise%0d_level", i), level_a, i >= 17);
         if (i == 17) chk("a_first_pv", pv_a, 0);
      end
      for (int i = 0; i < 40; i++) begin
         enc_a = 1'b0;
         tick();
         chk($sformatf("a_fall%0d_level", i), level_a, i < 17);
         chk($sformatf("a_fall%0d_stim", i), stim_a, 0);
      end

      // ---- reset in the middle of RISE_CHK ----
      enc_a = 1'b1;
      repeat (8) tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("a_rst_stim", stim_a, 0);
         chk("a_rst_level", level_a, 0);
      end
      rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         chk($sformatf("a_rel%0d_stim", k), stim_a, k == 17);
         chk($sformatf("a_rel%0d_level", k), level_a, k >= 17);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
